// File: rtl/nand_erase_block_cmd.sv
// rtl/nand_erase_block_cmd.sv - ONFI single-block erase sequencer (60h/row x3/D0h, tBERS wait, 70h status)
module nand_erase_block_cmd #(
  parameter int unsigned WE_LOW  = 2,
  parameter int unsigned WE_HIGH = 2,
  parameter int unsigned T_WB    = 10,
  parameter int unsigned T_WHR   = 6,
  parameter int unsigned RE_LOW  = 3,
  parameter logic [23:0] TIMEOUT = 24'd500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_erase_page,
  input  logic [23:0] erase_addr_row,
  output logic        end_erase_page,
  output logic        erase_fail,
  output logic        erase_busy,
  output logic        flash_ce_n,
  output logic        flash_cle,
  output logic        flash_ale,
  output logic        flash_we_n,
  output logic        flash_re_n,
  output logic [7:0]  flash_dq_out,
  output logic        flash_dq_oe,
  input  logic [7:0]  flash_dq_in,
  input  logic        flash_rb_n
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CMD1    = 4'd1;
  localparam logic [3:0] S_ADDR1   = 4'd2;
  localparam logic [3:0] S_ADDR2   = 4'd3;
  localparam logic [3:0] S_ADDR3   = 4'd4;
  localparam logic [3:0] S_CMD2    = 4'd5;
  localparam logic [3:0] S_WAITWB  = 4'd6;
  localparam logic [3:0] S_BUSY    = 4'd7;
  localparam logic [3:0] S_CMD3    = 4'd8;
  localparam logic [3:0] S_WAITWHR = 4'd9;
  localparam logic [3:0] S_READ    = 4'd10;
  localparam logic [3:0] S_DONE    = 4'd11;

  localparam logic [23:0] WR_LAST  = 24'(WE_LOW + WE_HIGH - 1);
  localparam logic [23:0] WE_LOW_C = 24'(WE_LOW);
  localparam logic [23:0] WB_LAST  = 24'(T_WB - 1);
  localparam logic [23:0] WHR_LAST = 24'(T_WHR - 1);
  localparam logic [23:0] RE_LAST  = 24'(RE_LOW - 1);

  logic [3:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] row_q, row_d;
  logic        en_prev_q, en_prev_d;
  logic        timeout_q, timeout_d;
  logic        rb_meta_q, rb_meta_d;
  logic        rb_sync_q, rb_sync_d;
  logic        start;

  logic        end_q, end_d;
  logic        fail_q, fail_d;
  logic        busy_q, busy_d;
  logic        ce_n_q, ce_n_d;
  logic        cle_q, cle_d;
  logic        ale_q, ale_d;
  logic        we_n_q, we_n_d;
  logic        re_n_q, re_n_d;
  logic [7:0]  dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        wr_state, cmd_state, addr_state;

  // Only bit 0 of the status byte carries the erase result.
  logic        unused_dq;
  assign unused_dq = ^flash_dq_in[7:1];

  // Sequencer next state, per-state counter and captured request fields.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    row_d     = row_q;
    en_prev_d = en_erase_page;
    rb_meta_d = flash_rb_n;
    rb_sync_d = rb_meta_q;
    start     = en_erase_page && !en_prev_q && (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CMD1;
          row_d     = erase_addr_row;
          timeout_d = 1'b0;
        end
      end
      S_CMD1:    if (cnt_q == WR_LAST) state_d = S_ADDR1;
      S_ADDR1:   if (cnt_q == WR_LAST) state_d = S_ADDR2;
      S_ADDR2:   if (cnt_q == WR_LAST) state_d = S_ADDR3;
      S_ADDR3:   if (cnt_q == WR_LAST) state_d = S_CMD2;
      S_CMD2:    if (cnt_q == WR_LAST) state_d = S_WAITWB;
      S_WAITWB:  if (cnt_q == WB_LAST) state_d = S_BUSY;
      S_BUSY: begin
        // Ready wins a tie with the timeout compare.
        if (rb_sync_q) begin
          state_d = S_CMD3;
        end else if (cnt_q == TIMEOUT) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_CMD3:    if (cnt_q == WR_LAST) state_d = S_WAITWHR;
      S_WAITWHR: if (cnt_q == WHR_LAST) state_d = S_READ;
      S_READ:    if (cnt_q == RE_LAST) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_DONE)) begin
      cnt_d = 24'd0;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  // Pin values are decoded from the upcoming state so every pin is a plain flop.
  always_comb begin
    cmd_state  = (state_d == S_CMD1) || (state_d == S_CMD2) || (state_d == S_CMD3);
    addr_state = (state_d == S_ADDR1) || (state_d == S_ADDR2) || (state_d == S_ADDR3);
    wr_state   = cmd_state || addr_state;
    ce_n_d     = (state_d == S_IDLE) || (state_d == S_DONE);
    cle_d      = cmd_state;
    ale_d      = addr_state;
    we_n_d     = !(wr_state && (cnt_d < WE_LOW_C));
    re_n_d     = (state_d != S_READ);
    dq_oe_d    = wr_state;
    busy_d     = (state_d != S_IDLE);
    end_d      = (state_d == S_DONE);
    case (state_d)
      S_CMD1:  dq_out_d = 8'h60;
      S_ADDR1: dq_out_d = row_d[7:0];
      S_ADDR2: dq_out_d = row_d[15:8];
      S_ADDR3: dq_out_d = row_d[23:16];
      S_CMD2:  dq_out_d = 8'hD0;
      S_CMD3:  dq_out_d = 8'h70;
      default: dq_out_d = 8'h00;
    endcase
    fail_d = fail_q;
    if (start) begin
      fail_d = 1'b0;
    end else if ((state_q == S_READ) && (state_d == S_DONE)) begin
      fail_d = flash_dq_in[0] | timeout_q;
    end else if ((state_q == S_BUSY) && (state_d == S_DONE)) begin
      fail_d = 1'b1;
    end
  end

  // State, counters, R/B# synchronizer and registered flash pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 24'd0;
      row_q     <= 24'd0;
      en_prev_q <= 1'b0;
      timeout_q <= 1'b0;
      rb_meta_q <= 1'b0;
      rb_sync_q <= 1'b0;
      end_q     <= 1'b0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
      ce_n_q    <= 1'b1;
      cle_q     <= 1'b0;
      ale_q     <= 1'b0;
      we_n_q    <= 1'b1;
      re_n_q    <= 1'b1;
      dq_out_q  <= 8'h00;
      dq_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      en_prev_q <= en_prev_d;
      timeout_q <= timeout_d;
      rb_meta_q <= rb_meta_d;
      rb_sync_q <= rb_sync_d;
      end_q     <= end_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
      ce_n_q    <= ce_n_d;
      cle_q     <= cle_d;
      ale_q     <= ale_d;
      we_n_q    <= we_n_d;
      re_n_q    <= re_n_d;
      dq_out_q  <= dq_out_d;
      dq_oe_q   <= dq_oe_d;
    end
  end

  assign end_erase_page = end_q;
  assign erase_fail     = fail_q;
  assign erase_busy     = busy_q;
  assign flash_ce_n     = ce_n_q;
  assign flash_cle      = cle_q;
  assign flash_ale      = ale_q;
  assign flash_we_n     = we_n_q;
  assign flash_re_n     = re_n_q;
  assign flash_dq_out   = dq_out_q;
  assign flash_dq_oe    = dq_oe_q;

endmodule

// File: tb/tb_nand_erase_block_cmd.sv
// tb/tb_nand_erase_block_cmd.sv - self-checking bench for nand_erase_block_cmd
module tb_nand_erase_block_cmd;
  localparam int T_WB   = 10;
  localparam int T_WHR  = 6;
  localparam int RE_LOW = 3;
  localparam int TO     = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [23:0] row = 24'd0;
  logic [7:0]  status_val = 8'hE0;
  logic        rb_n = 1'b1;
  logic        end_erase_page, erase_fail, erase_busy;
  logic        flash_ce_n, flash_cle, flash_ale, flash_we_n, flash_re_n, flash_dq_oe;
  logic [7:0]  flash_dq_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int S = 0;
  int rb_len = 0;
  int rb_hold = 0;
  logic we_prev = 1'b1;

  logic [10:0] exp_wr[$];
  logic [10:0] obs_wr[$];
  int          exp_end_cyc[$];
  int          obs_end_cyc[$];
  logic        exp_end_fail[$];
  logic        obs_end_fail[$];

  nand_erase_block_cmd #(
    .WE_LOW(2), .WE_HIGH(2), .T_WB(T_WB), .T_WHR(T_WHR), .RE_LOW(RE_LOW), .TIMEOUT(24'd1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_erase_page(en),
    .erase_addr_row(row),
    .end_erase_page(end_erase_page),
    .erase_fail(erase_fail),
    .erase_busy(erase_busy),
    .flash_ce_n(flash_ce_n),
    .flash_cle(flash_cle),
    .flash_ale(flash_ale),
    .flash_we_n(flash_we_n),
    .flash_re_n(flash_re_n),
    .flash_dq_out(flash_dq_out),
    .flash_dq_oe(flash_dq_oe),
    .flash_dq_in(status_val),
    .flash_rb_n(rb_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and flash model: record each WE# falling edge and every end pulse;
  // pull R/B# low for rb_len cycles starting with the D0h write.
  always @(negedge clk) begin
    if (rst && !flash_we_n && we_prev) begin
      obs_wr.push_back({flash_dq_oe, flash_cle, flash_ale, flash_dq_out});
    end
    if (rst && !flash_we_n && we_prev && flash_cle && flash_dq_out == 8'hD0) begin
      rb_hold <= rb_len - 1;
      rb_n    <= 1'b0;
    end else if (rb_hold > 0) begin
      rb_hold <= rb_hold - 1;
      rb_n    <= 1'b0;
    end else begin
      rb_n <= 1'b1;
    end
    if (end_erase_page) begin
      obs_end_cyc.push_back(cyc);
      obs_end_fail.push_back(erase_fail);
    end
    we_prev <= flash_we_n;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [23:0] r, input logic [7:0] st, input int len, input bit to);
    row        = r;
    status_val = st;
    rb_len     = len;
    en         = 1'b1;
    S          = cyc;
    exp_wr.push_back({3'b110, 8'h60});
    exp_wr.push_back({3'b101, r[7:0]});
    exp_wr.push_back({3'b101, r[15:8]});
    exp_wr.push_back({3'b101, r[23:16]});
    exp_wr.push_back({3'b110, 8'hD0});
    if (!to) exp_wr.push_back({3'b110, 8'h70});
    // D0h WE# falls at S+17, R/B# released len cycles later, two sync flops, then CMD3+WHR+READ.
    if (to) exp_end_cyc.push_back(S + 21 + T_WB + TO + 1);
    else    exp_end_cyc.push_back(S + 17 + len + 2 + 5 + T_WHR + RE_LOW);
    exp_end_fail.push_back(to | st[0]);
  endtask

  task automatic wait_end(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (end_erase_page) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if (flash_ce_n !== 1'b1 || flash_we_n !== 1'b1 || flash_re_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_pins_high got ce_n=%b we_n=%b re_n=%b exp 1 1 1", flash_ce_n, flash_we_n, flash_re_n);
    end
    checks++;
    if ({flash_cle, flash_ale, flash_dq_oe, flash_dq_out} !== 11'd0) begin
      errors++;
      $display("FAIL reset_bus_low got cle=%b ale=%b oe=%b dq=%h exp 0", flash_cle, flash_ale, flash_dq_oe, flash_dq_out);
    end
    checks++;
    if ({end_erase_page, erase_fail, erase_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status got end=%b fail=%b busy=%b exp 000", end_erase_page, erase_fail, erase_busy);
    end
    rst = 1'b1;
    step(3);
    checks++;
    if (erase_busy !== 1'b0 || flash_ce_n !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_release got busy=%b ce_n=%b exp 0 1", erase_busy, flash_ce_n);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int e;
    issue(24'h012345, 8'hE0, 200, 1'b0);
    step(1);
    checks++;
    if (erase_busy !== 1'b1 || flash_ce_n !== 1'b0 || flash_we_n !== 1'b0 || flash_cle !== 1'b1 || flash_dq_out !== 8'h60) begin
      errors++;
      $display("FAIL basic_start got busy=%b ce_n=%b we_n=%b cle=%b dq=%h exp 1 0 0 1 60", erase_busy, flash_ce_n, flash_we_n, flash_cle, flash_dq_out);
    end
    wait_end(400, ok);
    en = 1'b0;
    e = cyc;
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_end_seen got none exp pulse"); end
    checks++;
    if (erase_fail !== 1'b0 || flash_ce_n !== 1'b1 || flash_re_n !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_pins got fail=%b ce_n=%b re_n=%b exp 0 1 1", erase_fail, flash_ce_n, flash_re_n);
    end
    step(1);
    checks++;
    if (erase_busy !== 1'b0 || end_erase_page !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_fall got busy=%b end=%b at %0d exp 0 0 at %0d", erase_busy, end_erase_page, cyc, e + 1);
    end
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL basic_wr_count got %0d exp %0d", obs_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < obs_wr.size()) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL basic_wr%0d got %h exp %h", i, obs_wr[i], exp_wr[i]); end
    end
    checks++;
    if (obs_end_cyc.size() != 1 || obs_end_cyc[0] != exp_end_cyc[0] || obs_end_fail[0] !== exp_end_fail[0]) begin
      errors++;
      $display("FAIL basic_end got n=%0d cyc=%0d fail=%b exp n=1 cyc=%0d fail=%b", obs_end_cyc.size(), obs_end_cyc[0], obs_end_fail[0], exp_end_cyc[0], exp_end_fail[0]);
    end
    exp_wr.delete(); obs_wr.delete(); exp_end_cyc.delete(); obs_end_cyc.delete(); exp_end_fail.delete(); obs_end_fail.delete();
  endtask

  task automatic test_status_fail();
    bit ok;
    issue(24'h012345, 8'hE1, 200, 1'b0);
    wait_end(400, ok);
    en = 1'b0;
    checks++;
    if (!ok || erase_fail !== 1'b1) begin
      errors++;
      $display("FAIL status_fail_end got seen=%b fail=%b exp 1 1", ok, erase_fail);
    end
    step(20);
    checks++;
    if (erase_fail !== 1'b1) begin errors++; $display("FAIL status_fail_held got %b exp 1", erase_fail); end
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL status_wr_count got %0d exp %0d", obs_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < obs_wr.size()) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL status_wr%0d got %h exp %h", i, obs_wr[i], exp_wr[i]); end
    end
    checks++;
    if (obs_end_cyc.size() != 1 || obs_end_cyc[0] != exp_end_cyc[0] || obs_end_fail[0] !== exp_end_fail[0]) begin
      errors++;
      $display("FAIL status_end got n=%0d cyc=%0d fail=%b exp n=1 cyc=%0d fail=%b", obs_end_cyc.size(), obs_end_cyc[0], obs_end_fail[0], exp_end_cyc[0], exp_end_fail[0]);
    end
    exp_wr.delete(); obs_wr.delete(); exp_end_cyc.delete(); obs_end_cyc.delete(); exp_end_fail.delete(); obs_end_fail.delete();
  endtask

  task automatic test_retrigger();
    bit ok;
    issue(24'hABCDEF, 8'hE0, 150, 1'b0);
    step(1);
    checks++;
    if (erase_fail !== 1'b0 || erase_busy !== 1'b1) begin
      errors++;
      $display("FAIL retrig_start_clears_fail got fail=%b busy=%b exp 0 1", erase_fail, erase_busy);
    end
    step(7);
    en = 1'b0;
    step(1);
    en = 1'b1;
    wait_end(400, ok);
    step(60);
    en = 1'b0;
    step(2);
    checks++;
    if (!ok) begin errors++; $display("FAIL retrig_end_seen got none exp pulse"); end
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL retrig_wr_count got %0d exp %0d", obs_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < obs_wr.size()) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL retrig_wr%0d got %h exp %h", i, obs_wr[i], exp_wr[i]); end
    end
    checks++;
    if (obs_end_cyc.size() != 1 || obs_end_cyc[0] != exp_end_cyc[0] || obs_end_fail[0] !== exp_end_fail[0]) begin
      errors++;
      $display("FAIL retrig_end got n=%0d cyc=%0d fail=%b exp n=1 cyc=%0d fail=%b", obs_end_cyc.size(), obs_end_cyc[0], obs_end_fail[0], exp_end_cyc[0], exp_end_fail[0]);
    end
    exp_wr.delete(); obs_wr.delete(); exp_end_cyc.delete(); obs_end_cyc.delete(); exp_end_fail.delete(); obs_end_fail.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    issue(24'h00FFEE, 8'hE0, 1100, 1'b1);
    wait_end(1200, ok);
    en = 1'b0;
    checks++;
    if (!ok || erase_fail !== 1'b1) begin
      errors++;
      $display("FAIL timeout_end got seen=%b fail=%b exp 1 1", ok, erase_fail);
    end
    for (int i = 0; i < 300; i++) begin
      if (rb_n === 1'b1) break;
      step(1);
    end
    step(5);
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL timeout_wr_count got %0d exp %0d", obs_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < obs_wr.size()) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL timeout_wr%0d got %h exp %h", i, obs_wr[i], exp_wr[i]); end
    end
    checks++;
    if (obs_end_cyc.size() != 1 || obs_end_cyc[0] != exp_end_cyc[0] || obs_end_fail[0] !== exp_end_fail[0]) begin
      errors++;
      $display("FAIL timeout_end_time got n=%0d cyc=%0d fail=%b exp n=1 cyc=%0d fail=%b", obs_end_cyc.size(), obs_end_cyc[0], obs_end_fail[0], exp_end_cyc[0], exp_end_fail[0]);
    end
    exp_wr.delete(); obs_wr.delete(); exp_end_cyc.delete(); obs_end_cyc.delete(); exp_end_fail.delete(); obs_end_fail.delete();
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    issue(24'h111111, 8'hE0, 100, 1'b0);
    wait_end(400, ok1);
    en = 1'b0;
    step(1);
    issue(24'h000080, 8'hE0, 100, 1'b0);
    step(1);
    checks++;
    if (erase_busy !== 1'b1 || flash_cle !== 1'b1 || flash_dq_out !== 8'h60 || flash_we_n !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart got busy=%b cle=%b dq=%h we_n=%b exp 1 1 60 0", erase_busy, flash_cle, flash_dq_out, flash_we_n);
    end
    wait_end(400, ok2);
    en = 1'b0;
    step(3);
    checks++;
    if (!ok1 || !ok2) begin errors++; $display("FAIL b2b_end_seen got %b%b exp 11", ok1, ok2); end
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL b2b_wr_count got %0d exp %0d", obs_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < obs_wr.size()) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL b2b_wr%0d got %h exp %h", i, obs_wr[i], exp_wr[i]); end
    end
    checks++;
    if (obs_end_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_end_count got %0d exp 2", obs_end_cyc.size());
    end
    foreach (exp_end_cyc[i]) if (i < obs_end_cyc.size()) begin
      checks++;
      if (obs_end_cyc[i] != exp_end_cyc[i] || obs_end_fail[i] !== exp_end_fail[i]) begin
        errors++;
        $display("FAIL b2b_end%0d got cyc=%0d fail=%b exp cyc=%0d fail=%b", i, obs_end_cyc[i], obs_end_fail[i], exp_end_cyc[i], exp_end_fail[i]);
      end
    end
    exp_wr.delete(); obs_wr.delete(); exp_end_cyc.delete(); obs_end_cyc.delete(); exp_end_fail.delete(); obs_end_fail.delete();
  endtask

  task automatic test_reset_midop();
    bit ok;
    issue(24'h345678, 8'hE0, 100, 1'b0);
    step(10);
    checks++;
    if (flash_ale !== 1'b1 || flash_dq_out !== 8'h56) begin
      errors++;
      $display("FAIL midop_in_addr2 got ale=%b dq=%h exp 1 56", flash_ale, flash_dq_out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (flash_ce_n !== 1'b1 || flash_we_n !== 1'b1 || flash_cle !== 1'b0 || flash_ale !== 1'b0 ||
        flash_dq_oe !== 1'b0 || erase_busy !== 1'b0 || end_erase_page !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_pins got ce_n=%b we_n=%b cle=%b ale=%b oe=%b busy=%b end=%b exp 1 1 0 0 0 0 0",
               flash_ce_n, flash_we_n, flash_cle, flash_ale, flash_dq_oe, erase_busy, end_erase_page);
    end
    en = 1'b0;
    step(3);
    rst = 1'b1;
    step(50);
    checks++;
    if (obs_end_cyc.size() != 0) begin
      errors++;
      $display("FAIL midop_no_end got %0d pulses exp 0", obs_end_cyc.size());
    end
    exp_wr.delete(); obs_wr.delete(); exp_end_cyc.delete(); obs_end_cyc.delete(); exp_end_fail.delete(); obs_end_fail.delete();
    issue(24'h5A5A5A, 8'hE1, 100, 1'b0);
    wait_end(400, ok);
    en = 1'b0;
    step(2);
    checks++;
    if (!ok) begin errors++; $display("FAIL midop_rerun_end got none exp pulse"); end
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL midop_wr_count got %0d exp %0d", obs_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < obs_wr.size()) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL midop_wr%0d got %h exp %h", i, obs_wr[i], exp_wr[i]); end
    end
    checks++;
    if (obs_end_cyc.size() != 1 || obs_end_cyc[0] != exp_end_cyc[0] || obs_end_fail[0] !== exp_end_fail[0]) begin
      errors++;
      $display("FAIL midop_end got n=%0d cyc=%0d fail=%b exp n=1 cyc=%0d fail=%b", obs_end_cyc.size(), obs_end_cyc[0], obs_end_fail[0], exp_end_cyc[0], exp_end_fail[0]);
    end
    exp_wr.delete(); obs_wr.delete(); exp_end_cyc.delete(); obs_end_cyc.delete(); exp_end_fail.delete(); obs_end_fail.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_status_fail();
    test_retrigger();
    test_timeout();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nand_erase_block_cmd.md
# nand_erase_block_cmd

Per-block NAND erase command sequencer that sits directly downstream of the erase flash controller. It accepts one row address per request on `en_erase_page` / `erase_addr_row`. On the flash pins it issues the ONFI block-erase sequence: 60h, three row-address cycles, D0h. It then waits out tBERS on R/B#, reads status with 70h, and returns `end_erase_page` together with a pass/fail flag. The controller iterates blocks; this block performs exactly one erase per request.

## Interface
- `WE_LOW`, 2: clk cycles `flash_we_n` is held low per bus write cycle (≥1).
- `WE_HIGH`, 2: clk cycles `flash_we_n` is held high per bus write cycle (≥1).
- `T_WB`, 10: clk cycles after the D0h rising WE# edge before R/B# is sampled.
- `T_WHR`, 6: clk cycles from the 70h rising WE# edge to RE# falling.
- `RE_LOW`, 3: clk cycles `flash_re_n` is held low; `flash_dq_in` is sampled in the last one.
- `TIMEOUT`, 24'd500000: maximum clk cycles spent in BUSY.
- `clk` input 1: single clock; every flop is on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `en_erase_page` input 1: request level from the controller. A rising edge starts one erase.
- `erase_addr_row` input 24: row address, captured on the start cycle.
- `end_erase_page` output 1: one-cycle completion pulse.
- `erase_fail` output 1: result of the last erase. Valid from the `end_erase_page` cycle and held until the next start.
- `erase_busy` output 1: high from the start cycle through the `end_erase_page` cycle.
- `flash_ce_n`, `flash_cle`, `flash_ale`, `flash_we_n`, `flash_re_n` output 1 each: NAND control pins, all registered.
- `flash_dq_out` output 8: write data. `flash_dq_oe` output 1: high while driving the bus.
- `flash_dq_in` input 8: read data. `flash_rb_n` input 1: ready/busy pin, asynchronous.

## Operation
- Reset values: `flash_ce_n` = 1, `flash_we_n` = 1, `flash_re_n` = 1. `flash_cle`, `flash_ale`, `flash_dq_oe`, `flash_dq_out`, `end_erase_page`, `erase_fail` and `erase_busy` are all 0. The state is IDLE.
- Start condition: `en_erase_page` = 1 while its registered previous sample = 0 and the state is IDLE.
  - Rising edges in any other state are ignored.
  - A level held high across DONE does not restart the sequence.
- States: IDLE → CMD1 → ADDR1 → ADDR2 → ADDR3 → CMD2 → WAITWB → BUSY → CMD3 → WAITWHR → READ → DONE → IDLE.
- Bus write cycle, used in CMD1, ADDR1–3, CMD2 and CMD3:
  - `flash_dq_oe` = 1 and the byte is on `flash_dq_out` for the whole cycle.
  - `flash_we_n` is low for WE_LOW clocks, then high for WE_HIGH clocks.
  - CLE = 1 in CMD states and ALE = 1 in ADDR states, held through the whole cycle.
- Bytes written, in order: 60h, `row[7:0]`, `row[15:8]`, `row[23:16]`, D0h, and later 70h.
- `flash_ce_n` = 0 from CMD1 entry through READ exit, and 1 in IDLE and DONE.
- WAITWB counts T_WB clocks, then enters BUSY.
- BUSY:
  - Watches `rb_sync`, the output of a 2-flop synchronizer on `flash_rb_n`.
  - `rb_sync` = 1 moves to CMD3.
  - If the 24-bit cycle counter reaches TIMEOUT first, the timeout flag is set, the status read is skipped, and the state goes straight to DONE.
- READ:
  - `flash_dq_oe` = 0 and `flash_re_n` = 0 for RE_LOW clocks.
  - The status byte is captured from `flash_dq_in` on the last low clock.
  - `flash_re_n` returns high on entry to DONE.
- DONE lasts one cycle. `end_erase_page` = 1 and `erase_fail` = `status[0]` | timeout.
- Counters clear on every state change. There is no arithmetic wrap: the TIMEOUT compare stops the BUSY counter before overflow.
- Reset mid-operation forces all outputs to their reset values on the same edge. No `end_erase_page` pulse is generated.

## Timing
- Start edge at cycle S:
  - `erase_busy` rises at S+1.
  - CMD1 begins at S+1 and `flash_we_n` falls at S+1.
- Each write cycle lasts WE_LOW+WE_HIGH clocks, 4 with the defaults. CMD2 therefore ends at S+20.
- BUSY is entered at S+21+T_WB.
- After `rb_sync` rises at cycle R:
  - CMD3 starts at R+1.
  - READ starts at R+5+T_WHR.
  - DONE / `end_erase_page` occurs at R+5+T_WHR+RE_LOW.
- `erase_busy` falls in the cycle after DONE.
- The earliest possible next start is the cycle after DONE. This matches the controller dropping `en_erase_page` on `end_erase_page` and re-raising it.

## Test plan
- **Basic erase:** `erase_addr_row` = 24'h012345, `rb_n` low for 200 clocks, status 8'hE0 → DQ writes 60h, 45h, 23h, 01h, D0h, 70h with correct CLE/ALE; one `end_erase_page` pulse; `erase_fail` = 0.
- **Status fail:** same stimulus with status 8'hE1 → `erase_fail` = 1 on the end pulse and held high until the next start.
- **R/B# timeout:** `flash_rb_n` stuck low, TIMEOUT = 1000 → no 70h issued; end pulse at S+21+T_WB+1000+1; `erase_fail` = 1.
- **Ignored re-trigger:** `en_erase_page` pulses low/high mid-sequence → no restart and exactly one end pulse. Holding it high after DONE gives no second erase.
- **Back-to-back:** controller-style request, low for 1 cycle after the end pulse, then high with row 24'h000080 → second sequence starts and its address bytes are 80h, 00h, 00h.
- **Reset mid-op:** `rst` = 0 during ADDR2 → same edge gives `ce_n` = 1, `we_n` = 1, `cle` = 0, `ale` = 0, `dq_oe` = 0, `busy` = 0, no end pulse; after release, a new request runs normally.
